// File: rtl/cmd_threshold_ctrl_if.sv
// ---------------------------------------------------------------------------
// cmd_threshold_ctrl_if
//   Groups the inputs that feed cmd_threshold_ctrl into one bundle.
//   Command message (from the UART receiver):
//     chr_cmd, chr_val0, chr_val1 : ASCII command letter and two value digits
//     rx_msg_done                 : level, high while a complete message is held
//   Sensor sample:
//     temperature (deg C), humidity (%RH) : fresh when sample_valid pulses
//     sample_valid                        : one-cycle strobe
//   master : the side that produces messages and samples
//   slave  : cmd_threshold_ctrl
// ---------------------------------------------------------------------------
interface cmd_threshold_ctrl_if;
  logic [7:0] chr_cmd;
  logic [7:0] chr_val0;
  logic [7:0] chr_val1;
  logic       rx_msg_done;
  logic [7:0] temperature;
  logic [7:0] humidity;
  logic       sample_valid;

  modport master (
    output chr_cmd, chr_val0, chr_val1, rx_msg_done,
    output temperature, humidity, sample_valid
  );

  modport slave (
    input chr_cmd, chr_val0, chr_val1, rx_msg_done,
    input temperature, humidity, sample_valid
  );
endinterface

// File: rtl/cmd_threshold_ctrl.sv
// ---------------------------------------------------------------------------
// cmd_threshold_ctrl
//   Decodes three-character ASCII commands that set temperature/humidity
//   thresholds or force the fan/humidifier LEDs (manual mode), and drives the
//   LEDs with hysteresis from sensor samples while in auto mode.
//
//   Commands: 'A'nn max_temp, 'B'nn min_temp, 'C'nn max_hum, 'D'nn min_hum,
//             'L'fh manual mode with led_fan=f, led_hum=h (f,h in '0'/'1').
//   A message is decoded over IDLE -> DECODE -> APPLY, one cycle each.
//
//   Ports:
//     clk_100Mhz, rst_n           : clock, asynchronous active-low reset
//     bus (slave)                 : command message and sensor sample inputs
//     max_temp/min_temp/max_hum/min_hum : current thresholds (0..99)
//     led_fan, led_hum            : actuator LEDs
//     manual_mode                 : high while a manual 'L' command is active
//     cmd_err                     : high during APPLY of a rejected message
// ---------------------------------------------------------------------------
module cmd_threshold_ctrl #(
  parameter logic [6:0]  DEF_MAX_TEMP   = 7'd30,
  parameter logic [6:0]  DEF_MIN_TEMP   = 7'd10,
  parameter logic [6:0]  DEF_MAX_HUM    = 7'd70,
  parameter logic [6:0]  DEF_MIN_HUM    = 7'd30,
  parameter logic [31:0] MANUAL_TIMEOUT = 32'd1_000_000_000
) (
  input  logic                clk_100Mhz,
  input  logic                rst_n,
  cmd_threshold_ctrl_if.slave bus,
  output logic [6:0]          max_temp,
  output logic [6:0]          min_temp,
  output logic [6:0]          max_hum,
  output logic [6:0]          min_hum,
  output logic                led_fan,
  output logic                led_hum,
  output logic                manual_mode,
  output logic                cmd_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    APPLY  = 2'd2
  } state_t;

  localparam logic [7:0] CMD_MAX_TEMP = 8'h41;  // 'A'
  localparam logic [7:0] CMD_MIN_TEMP = 8'h42;  // 'B'
  localparam logic [7:0] CMD_MAX_HUM  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_MIN_HUM  = 8'h44;  // 'D'
  localparam logic [7:0] CMD_MANUAL   = 8'h4C;  // 'L'

  state_t      state_q, state_d;
  logic        done_q, done_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        digits_ok_q, digits_ok_d;  // both value chars are '0'..'9'
  logic        bin_ok_q, bin_ok_d;        // both value chars are '0' or '1'
  logic [6:0]  value_q, value_d;
  logic [6:0]  max_temp_q, max_temp_d;
  logic [6:0]  min_temp_q, min_temp_d;
  logic [6:0]  max_hum_q, max_hum_d;
  logic [6:0]  min_hum_q, min_hum_d;
  logic        fan_q, fan_d;
  logic        hum_q, hum_d;
  logic        manual_q, manual_d;
  logic [31:0] cnt_q, cnt_d;
  logic        new_msg;
  logic        accept;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic is_bin(input logic [7:0] c);
    return (c == 8'h30) || (c == 8'h31);
  endfunction

  // Validity of the latched message, judged against the thresholds as they
  // stand during APPLY.
  always_comb begin
    accept = 1'b0;
    if (digits_ok_q) begin
      case (cmd_q)
        CMD_MAX_TEMP: accept = (value_q >= min_temp_q);
        CMD_MIN_TEMP: accept = (value_q <= max_temp_q);
        CMD_MAX_HUM:  accept = (value_q >= min_hum_q);
        CMD_MIN_HUM:  accept = (value_q <= max_hum_q);
        CMD_MANUAL:   accept = bin_ok_q;
        default:      accept = 1'b0;
      endcase
    end
  end

  // NOTE: every signal gets its hold value first so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    done_d      = bus.rx_msg_done;
    cmd_d       = cmd_q;
    digits_ok_d = digits_ok_q;
    bin_ok_d    = bin_ok_q;
    value_d     = value_q;
    max_temp_d  = max_temp_q;
    min_temp_d  = min_temp_q;
    max_hum_d   = max_hum_q;
    min_hum_d   = min_hum_q;
    fan_d       = fan_q;
    hum_d       = hum_q;
    manual_d    = manual_q;
    cnt_d       = cnt_q;

    // Rising edge of the message-held level; only acted on in IDLE.
    new_msg = bus.rx_msg_done & ~done_q;

    unique case (state_q)
      IDLE: begin
        if (new_msg) state_d = DECODE;
      end
      DECODE: begin
        cmd_d       = bus.chr_cmd;
        digits_ok_d = is_digit(bus.chr_val0) && is_digit(bus.chr_val1);
        bin_ok_d    = is_bin(bus.chr_val0) && is_bin(bus.chr_val1);
        // The low nibble of an ASCII digit is its value; 9*10+9 fits 7 bits.
        value_d     = {3'b000, bus.chr_val0[3:0]} * 7'd10
                    + {3'b000, bus.chr_val1[3:0]};
        state_d     = APPLY;
      end
      APPLY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Auto-mode hysteresis against the thresholds currently in force.
    if (bus.sample_valid && !manual_q) begin
      if (bus.temperature > {1'b0, max_temp_q})      fan_d = 1'b1;
      else if (bus.temperature < {1'b0, min_temp_q}) fan_d = 1'b0;
      if (bus.humidity < {1'b0, min_hum_q})          hum_d = 1'b1;
      else if (bus.humidity > {1'b0, max_hum_q})     hum_d = 1'b0;
    end

    // Manual timeout: mode drops on the cycle the count reaches zero; the
    // LEDs keep their level until the next sample arrives.
    if (manual_q) begin
      if (cnt_q <= 32'd1) begin
        manual_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
    end

    // An accepted command overrides the sample and timeout updates above.
    if (state_q == APPLY && accept) begin
      case (cmd_q)
        CMD_MAX_TEMP: max_temp_d = value_q;
        CMD_MIN_TEMP: min_temp_d = value_q;
        CMD_MAX_HUM:  max_hum_d  = value_q;
        CMD_MIN_HUM:  min_hum_d  = value_q;
        CMD_MANUAL: begin
          // Binary digits give value 0, 1, 10 or 11: tens = fan, units = hum.
          manual_d = 1'b1;
          cnt_d    = MANUAL_TIMEOUT;
          fan_d    = (value_q >= 7'd10);
          hum_d    = value_q[0];
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      done_q      <= 1'b1;  // a message already held at release is not new
      cmd_q       <= '0;
      digits_ok_q <= 1'b0;
      bin_ok_q    <= 1'b0;
      value_q     <= '0;
      max_temp_q  <= DEF_MAX_TEMP;
      min_temp_q  <= DEF_MIN_TEMP;
      max_hum_q   <= DEF_MAX_HUM;
      min_hum_q   <= DEF_MIN_HUM;
      fan_q       <= 1'b0;
      hum_q       <= 1'b0;
      manual_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      cmd_q       <= cmd_d;
      digits_ok_q <= digits_ok_d;
      bin_ok_q    <= bin_ok_d;
      value_q     <= value_d;
      max_temp_q  <= max_temp_d;
      min_temp_q  <= min_temp_d;
      max_hum_q   <= max_hum_d;
      min_hum_q   <= min_hum_d;
      fan_q       <= fan_d;
      hum_q       <= hum_d;
      manual_q    <= manual_d;
      cnt_q       <= cnt_d;
    end
  end

  assign max_temp    = max_temp_q;
  assign min_temp    = min_temp_q;
  assign max_hum     = max_hum_q;
  assign min_hum     = min_hum_q;
  assign led_fan     = fan_q;
  assign led_hum     = hum_q;
  assign manual_mode = manual_q;
  assign cmd_err     = (state_q == APPLY) && !accept;

endmodule

// File: tb/tb_cmd_threshold_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cmd_threshold_ctrl
//   Directed scenarios followed by randomized messages and samples, all
//   compared every cycle against a behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_cmd_threshold_ctrl;

  localparam int TIMEOUT = 100;

  logic       clk_100Mhz = 1'b0;
  logic       rst_n      = 1'b0;
  logic [6:0] max_temp, min_temp, max_hum, min_hum;
  logic       led_fan, led_hum, manual_mode, cmd_err;

  always #5 clk_100Mhz = ~clk_100Mhz;

  cmd_threshold_ctrl_if bus ();

  cmd_threshold_ctrl #(
    .MANUAL_TIMEOUT(32'(TIMEOUT))
  ) dut (
    .clk_100Mhz (clk_100Mhz),
    .rst_n      (rst_n),
    .bus        (bus),
    .max_temp   (max_temp),
    .min_temp   (min_temp),
    .max_hum    (max_hum),
    .min_hum    (min_hum),
    .led_fan    (led_fan),
    .led_hum    (led_hum),
    .manual_mode(manual_mode),
    .cmd_err    (cmd_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // thr: 0 max_temp, 1 min_temp, 2 max_hum, 3 min_hum
  int       thr [4];
  int       m_fan, m_hum, m_man, m_left;
  int       m_age;          // -1 no message, 0 being captured, 1 being applied
  bit       m_prev_done;
  bit [7:0] cap_c, cap_a, cap_b;

  function automatic int digit(input bit [7:0] ch);
    return (ch >= 8'h30 && ch <= 8'h39) ? int'(ch) - 48 : -1;
  endfunction

  function automatic bit model_accept(input bit [7:0] c, input bit [7:0] a, input bit [7:0] b);
    int val;
    if (digit(a) < 0 || digit(b) < 0) return 1'b0;
    val = digit(a) * 10 + digit(b);
    case (c)
      8'h41:   return val >= thr[1];
      8'h42:   return val <= thr[0];
      8'h43:   return val >= thr[3];
      8'h44:   return val <= thr[2];
      8'h4C:   return (digit(a) <= 1) && (digit(b) <= 1);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    thr[0] = 30; thr[1] = 10; thr[2] = 70; thr[3] = 30;
    m_fan = 0; m_hum = 0; m_man = 0; m_left = 0;
    m_age = -1; m_prev_done = 1'b1;
  endtask

  task automatic model_step();
    int  f, h, man, left, val;
    bit  is_new;
    f = m_fan; h = m_hum; man = m_man; left = m_left;
    is_new = bus.rx_msg_done && !m_prev_done && (m_age < 0);
    if (bus.sample_valid && m_man == 0) begin
      if (int'(bus.temperature) > thr[0])      f = 1;
      else if (int'(bus.temperature) < thr[1]) f = 0;
      if (int'(bus.humidity) < thr[3])         h = 1;
      else if (int'(bus.humidity) > thr[2])    h = 0;
    end
    if (m_man != 0) begin
      left = left - 1;
      if (left <= 0) begin man = 0; left = 0; end
    end
    if (m_age == 1 && model_accept(cap_c, cap_a, cap_b)) begin
      val = digit(cap_a) * 10 + digit(cap_b);
      case (cap_c)
        8'h41: thr[0] = val;
        8'h42: thr[1] = val;
        8'h43: thr[2] = val;
        8'h44: thr[3] = val;
        default: begin
          man = 1; left = TIMEOUT;
          f = digit(cap_a); h = digit(cap_b);
        end
      endcase
    end
    if (m_age == 1) m_age = -1;
    else if (m_age == 0) begin
      cap_c = bus.chr_cmd; cap_a = bus.chr_val0; cap_b = bus.chr_val1;
      m_age = 1;
    end else if (is_new) m_age = 0;
    m_prev_done = bus.rx_msg_done;
    m_fan = f; m_hum = h; m_man = man; m_left = left;
  endtask

  always @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Every cycle, away from the active edge, compare all outputs.
  always @(negedge clk_100Mhz) begin
    check("max_temp", 32'(max_temp), thr[0]);
    check("min_temp", 32'(min_temp), thr[1]);
    check("max_hum", 32'(max_hum), thr[2]);
    check("min_hum", 32'(min_hum), thr[3]);
    check("led_fan", 32'(led_fan), m_fan);
    check("led_hum", 32'(led_hum), m_hum);
    check("manual_mode", 32'(manual_mode), m_man);
    check("cmd_err", 32'(cmd_err), (m_age == 1 && !model_accept(cap_c, cap_a, cap_b)) ? 1 : 0);
  end

  // ---------------- stimulus ----------------
  bit rand_samples = 1'b0;

  task automatic step();
    @(negedge clk_100Mhz);
    if (rand_samples) begin
      bus.sample_valid = ($urandom_range(0, 3) == 0);
      bus.temperature  = 8'($urandom_range(0, 110));
      bus.humidity     = 8'($urandom_range(0, 110));
    end else begin
      bus.sample_valid = 1'b0;
    end
  endtask

  task automatic set_msg(input bit [7:0] c, input bit [7:0] a, input bit [7:0] b);
    bus.chr_cmd = c; bus.chr_val0 = a; bus.chr_val1 = b; bus.rx_msg_done = 1'b1;
  endtask

  task automatic sample(input int t, input int h);
    bus.temperature = 8'(t); bus.humidity = 8'(h); bus.sample_valid = 1'b1;
    step();
  endtask

  // Message with the error flag checked in the APPLY cycle and just after.
  task automatic send_chk(input string tag, input bit [7:0] c, input bit [7:0] a,
                          input bit [7:0] b, input bit exp_err);
    set_msg(c, a, b);
    step(); step();
    check({tag, "_err_apply"}, 32'(cmd_err), 32'(exp_err));
    step();
    check({tag, "_err_after"}, 32'(cmd_err), 0);
    bus.rx_msg_done = 1'b0;
    step();
  endtask

  task automatic send_rand(input bit [7:0] c, input bit [7:0] a, input bit [7:0] b,
                           input int hold, input int gap);
    set_msg(c, a, b);
    repeat (hold) step();
    bus.rx_msg_done = 1'b0;
    bus.chr_cmd  = 8'($urandom);
    bus.chr_val0 = 8'($urandom);
    bus.chr_val1 = 8'($urandom);
    repeat (gap) step();
  endtask

  initial begin
    int       n;
    bit [7:0] c, a, b;
    model_reset();
    bus.sample_valid = 1'b0;
    bus.temperature  = 8'd0;
    bus.humidity     = 8'd0;
    // Message already held across reset release must not be decoded.
    set_msg("A", "4", "0");
    step();
    check("rst_max_temp", 32'(max_temp), 30);
    check("rst_min_hum", 32'(min_hum), 30);
    check("rst_manual", 32'(manual_mode), 0);
    #2 rst_n = 1'b1;
    repeat (5) step();
    check("held_at_release", 32'(max_temp), 30);
    bus.rx_msg_done = 1'b0;
    step();

    // Auto hysteresis at default thresholds.
    sample(31, 50); check("fan_on_31", 32'(led_fan), 1);
    sample(20, 50); check("fan_hold_20", 32'(led_fan), 1);
    sample(9, 50);  check("fan_off_9", 32'(led_fan), 0);
    sample(20, 29); check("hum_on_29", 32'(led_hum), 1);
    sample(20, 71); check("hum_off_71", 32'(led_hum), 0);

    // Range violation, then the 3-cycle update latency.
    send_chk("B40", "B", "4", "0", 1'b1);
    check("B40_min_temp", 32'(min_temp), 10);
    set_msg("A", "3", "5");
    step(); check("A35_e0", 32'(max_temp), 30);
    step(); check("A35_e1", 32'(max_temp), 30); check("A35_err", 32'(cmd_err), 0);
    step(); check("A35_e2", 32'(max_temp), 35);
    bus.rx_msg_done = 1'b0;
    step();
    send_chk("A10_eq", "A", "1", "0", 1'b0);
    check("A10_eq_val", 32'(max_temp), 10);
    send_chk("C7x", "C", "7", "x", 1'b1);
    check("C7x_max_hum", 32'(max_hum), 70);
    send_chk("Z", "Z", "1", "2", 1'b1);

    // Manual mode and its timeout.
    set_msg("L", "1", "0");
    repeat (3) step();
    check("L10_manual", 32'(manual_mode), 1);
    check("L10_fan", 32'(led_fan), 1);
    check("L10_hum", 32'(led_hum), 0);
    bus.rx_msg_done = 1'b0;
    sample(5, 10); n = 1;
    check("L10_ignore_fan", 32'(led_fan), 1);
    check("L10_ignore_hum", 32'(led_hum), 0);
    while (manual_mode === 1'b1 && n < 150) begin step(); n++; end
    check("L10_len", n, TIMEOUT);
    check("L10_hold_fan", 32'(led_fan), 1);
    sample(9, 29);
    check("auto_fan", 32'(led_fan), 0);
    check("auto_hum", 32'(led_hum), 1);

    // Re-issued 'L' landing on the expiry cycle keeps manual mode.
    send_chk("L01", "L", "0", "1", 1'b0);
    n = 0;
    while (m_left != 3 && n < 200) begin step(); n++; end
    if (m_left != 3) check("wait_left", m_left, 3);
    set_msg("L", "1", "1");
    repeat (3) step();
    check("reL_manual", 32'(manual_mode), 1);
    check("reL_fan", 32'(led_fan), 1);
    bus.rx_msg_done = 1'b0;
    n = 0;
    while (manual_mode === 1'b1 && n < 150) begin step(); n++; end
    check("reL_len", n, TIMEOUT);

    // Reset during DECODE, message still held at release.
    set_msg("A", "5", "0");
    step();
    #2 rst_n = 1'b0;
    step(); step();
    #2 rst_n = 1'b1;
    repeat (4) step();
    check("rstdec_max_temp", 32'(max_temp), 30);
    check("rstdec_err", 32'(cmd_err), 0);
    bus.rx_msg_done = 1'b0;
    step();

    // Randomized messages and samples.
    rand_samples = 1'b1;
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0, 1:    c = "A";
        2, 3:    c = "B";
        4, 5:    c = "C";
        6, 7:    c = "D";
        8:       c = "L";
        default: c = ($urandom_range(0, 1) == 0) ? "Z" : "L";
      endcase
      if (c == "L" && $urandom_range(0, 3) != 0) begin
        a = 8'h30 + 8'($urandom_range(0, 1));
        b = 8'h30 + 8'($urandom_range(0, 1));
      end else begin
        a = 8'h30 + 8'($urandom_range(0, 9));
        b = 8'h30 + 8'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 15) == 0) a = 8'($urandom);
      if ($urandom_range(0, 15) == 0) b = 8'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst_n = 1'b0;
        step();
        #2 rst_n = 1'b1;
      end
      send_rand(c, a, b, $urandom_range(1, 4), $urandom_range(1, 3));
    end
    rand_samples = 1'b0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_threshold_ctrl.md
CMD_THRESHOLD_CTRL -- requirements
Module: cmd_threshold_ctrl

Interface
REQ-001 SHALL have parameter DEF_MAX_TEMP, default 7'd30, reset value of max_temp.
REQ-002 SHALL have parameter DEF_MIN_TEMP, default 7'd10, reset value of min_temp.
REQ-003 SHALL have parameter DEF_MAX_HUM, default 7'd70, reset value of max_hum.
REQ-004 SHALL have parameter DEF_MIN_HUM, default 7'd30, reset value of min_hum.
REQ-005 SHALL have parameter MANUAL_TIMEOUT, default 32'd1_000_000_000, clock cycles of manual mode before auto mode resumes.
REQ-006 SHALL have ports: clk_100Mhz in 1, system clock; rst_n in 1, reset; reset is rst_n, asynchronous, active-low; clock is clk_100Mhz.
REQ-007 SHALL have ports: chr_cmd, chr_val0, chr_val1 in 8 each, ASCII command fields; rx_msg_done in 1, level, high while a complete message is held.
REQ-008 SHALL have ports: temperature in 8, deg C; humidity in 8, %RH; sample_valid in 1, one-cycle pulse when temperature/humidity are fresh.
REQ-009 SHALL have ports: max_temp, min_temp, max_hum, min_hum out 7 each; led_fan out 1; led_hum out 1; manual_mode out 1; cmd_err out 1, one-cycle pulse.

Function
REQ-010 SHALL register rx_msg_done once (done_q); new message = rx_msg_done & ~done_q, detected in IDLE only; edges outside IDLE are dropped.
REQ-011 SHALL run FSM IDLE -> DECODE -> APPLY -> IDLE, one cycle per state; DECODE latches chr_cmd/chr_val0/chr_val1 and computes validity and value.
REQ-012 SHALL update outputs on the clock edge leaving APPLY: 3 cycles after rx_msg_done is first sampled high.
REQ-013 SHALL treat a digit as valid only in 0x30..0x39; value = 10*(val0-0x30) + (val1-0x30), range 0..99, 7 bits, no overflow possible.
REQ-014 SHALL map 'A'(0x41)->max_temp, 'B'(0x42)->min_temp, 'C'(0x43)->max_hum, 'D'(0x44)->min_hum.
REQ-015 SHALL reject 'A' if value < min_temp, 'B' if value > max_temp, 'C' if value < min_hum, 'D' if value > max_hum; equality accepted.
REQ-016 SHALL for 'L'(0x4C) require both values in {'0','1'}; then set manual_mode=1, led_fan=(val0=='1'), led_hum=(val1=='1'), load timeout counter with MANUAL_TIMEOUT.
REQ-017 SHALL on any rejection (invalid digit, unknown cmd, range violation) pulse cmd_err for the APPLY cycle and leave all other outputs unchanged.
REQ-018 SHALL in auto mode on sample_valid: led_fan<=1 if temperature > max_temp, <=0 if temperature < min_temp, else hold (hysteresis); compare with thresholds zero-extended to 8 bits.
REQ-019 SHALL in auto mode on sample_valid: led_hum<=1 if humidity < min_hum, <=0 if humidity > max_hum, else hold.
REQ-020 SHALL ignore sample_valid for led_fan/led_hum while manual_mode=1.
REQ-021 SHALL decrement the timeout counter each cycle in manual mode; at 0 clear manual_mode, keep LED levels until next sample_valid.
REQ-022 SHALL on sample_valid coinciding with APPLY evaluate hysteresis against pre-update thresholds.
REQ-023 SHALL on a valid 'L' in APPLY coinciding with timeout expiry give priority to 'L' (manual stays 1, counter reloaded).
REQ-024 SHALL accept a repeated identical command (new edge) and reapply it, reloading the timeout for 'L'.

Reset
REQ-025 SHALL on rst_n low immediately set thresholds to DEF_* values, led_fan=0, led_hum=0, manual_mode=0, cmd_err=0, FSM=IDLE, counter=0.
REQ-026 SHALL reset done_q to 1 so rx_msg_done already high at reset release is not decoded.
REQ-027 SHALL abandon any in-flight DECODE/APPLY on reset with no output change beyond REQ-025.

Verification
REQ-028 'A','3','5' with done rising -> max_temp=35 exactly 3 cycles later, cmd_err=0.
REQ-029 'B','4','0' with max_temp=30 -> cmd_err pulse 1 cycle, min_temp stays 10.
REQ-030 'C','7','x' -> cmd_err pulse, max_hum stays 70; unknown 'Z' -> cmd_err pulse.
REQ-031 Auto defaults: sample_valid temp=31 -> led_fan=1; temp=20 -> stays 1; temp=9 -> 0; hum=29 -> led_hum=1; hum=71 -> 0.
REQ-032 'L','1','0' with MANUAL_TIMEOUT=100 -> manual_mode=1, led_fan=1, led_hum=0, sample_valid ignored; manual_mode=0 after 100 cycles; re-'L' at cycle 99 extends it.
REQ-033 rst_n pulsed during DECODE of 'A','5','0' -> max_temp=30, no cmd_err; rx_msg_done high at release -> no decode.
